stereo_pan_mixer: RTL and testbench

Parametrised successor to the two-bit stereo mute unit: it mixes NUM_VOICES per-note samples into independent left/right codec samples, using per-voice pan gains selected by a button-cycled mode. The modes are mono, hard-left, hard-right, fixed spread, and a swept auto-pan. It sits between the music player's per-note sample bus and the codec interface. The button input is a debounced one-cycle press pulse from a button_press_unit.

---
 rtl/stereo_pkg.sv | 29 ++
 rtl/auto_pan_sweep.sv | 62 ++++++
 rtl/stereo_pan_mixer.sv | 203 ++++++++++++++++++++
 tb/tb_stereo_pan_mixer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo pan mixer.
//   pan_mode_e  : button-cycled pan mode (MONO, LEFT, RIGHT, SPREAD, AUTO)
//   MODE_W      : width of the mode encoding
//   spread_pos  : fixed pan position of voice i out of n for full scale g
//   acc_width   : accumulator width that cannot overflow for nv voices
package stereo_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_MONO   = 3'd0,
    MODE_LEFT   = 3'd1,
    MODE_RIGHT  = 3'd2,
    MODE_SPREAD = 3'd3,
    MODE_AUTO   = 3'd4
  } pan_mode_e;

  // Voices are spread evenly from hard left to hard right; a single voice sits centred.
  function automatic int spread_pos(input int i, input int n, input int g);
    if (n <= 1) return g / 2;
    return (i * g) / (n - 1);
  endfunction

  // Product is sw+gw+2 bits; summing nv of them needs clog2(nv) more.
  function automatic int acc_width(input int sw, input int gw, input int nv);
    return sw + gw + 2 + $clog2(nv);
  endfunction

endpackage

// File: rtl/auto_pan_sweep.sv
// Triangle pan-position generator for the AUTO mode.
//   clk, reset_n : clock, asynchronous active-low reset
//   accept       : one pulse per accepted sample; the sweep divides this strobe
//   p_auto       : current pan position, 0..2^GAIN_WIDTH, resets to the centre
// The position moves one step every AUTO_PAN_DIV accepts, bouncing between the
// endpoints; each endpoint is visited once per pass, never repeated.
module auto_pan_sweep #(
  parameter int GAIN_WIDTH   = 4,
  parameter int AUTO_PAN_DIV = 4800
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  accept,
  output logic [GAIN_WIDTH:0]   p_auto
);

  localparam int CNT_W = (AUTO_PAN_DIV > 1) ? $clog2(AUTO_PAN_DIV) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(AUTO_PAN_DIV - 1);
  localparam logic [GAIN_WIDTH:0] P_FULL   = {1'b1, {GAIN_WIDTH{1'b0}}};
  localparam logic [GAIN_WIDTH:0] P_HALF   = P_FULL >> 1;
  localparam logic [GAIN_WIDTH:0] P_ONE    = (GAIN_WIDTH+1)'(1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAIN_WIDTH:0] pos_q, pos_d;
  logic                up_q, up_d;

  always_comb begin
    cnt_d = cnt_q;
    pos_d = pos_q;
    up_d  = up_q;
    if (accept) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        // Direction flips on arrival at an endpoint so the next step leaves it.
        if (up_q) begin
          pos_d = pos_q + P_ONE;
          if (pos_q == P_FULL - P_ONE) up_d = 1'b0;
        end else begin
          pos_d = pos_q - P_ONE;
          if (pos_q == P_ONE) up_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      pos_q <= P_HALF;
      up_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      up_q  <= up_d;
    end
  end

  assign p_auto = pos_q;

endmodule

// File: rtl/stereo_pan_mixer.sv
// Multi-voice stereo mixer with button-selected pan modes.
//   clk, reset_n   : clock, asynchronous active-low reset
//   button_press   : one-cycle pulse, advances MONO->LEFT->RIGHT->SPREAD->AUTO->MONO
//   new_sample     : one-cycle pulse, voice_samples valid (dropped while busy)
//   voice_samples  : NUM_VOICES signed samples, voice i at [i*SW +: SW]
//   left_sample    : signed mixed left output, held until next result
//   right_sample   : signed mixed right output, held until next result
//   out_valid      : one-cycle pulse when the outputs update
//   busy           : high while a mix is in flight
//   overrun        : one-cycle pulse when a new_sample is dropped
//   mode           : current pan mode
// One voice is multiply-accumulated per cycle, so a mix takes NUM_VOICES+2 cycles.
module stereo_pan_mixer
  import stereo_pkg::*;
#(
  parameter int NUM_VOICES   = 3,
  parameter int SAMPLE_WIDTH = 16,
  parameter int GAIN_WIDTH   = 4,
  parameter int AUTO_PAN_DIV = 4800
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               button_press,
  input  logic                               new_sample,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_samples,
  output logic [SAMPLE_WIDTH-1:0]            left_sample,
  output logic [SAMPLE_WIDTH-1:0]            right_sample,
  output logic                               out_valid,
  output logic                               busy,
  output logic                               overrun,
  output logic [MODE_W-1:0]                  mode
);

  localparam int PROD_W = SAMPLE_WIDTH + GAIN_WIDTH + 2;
  localparam int ACC_W  = acc_width(SAMPLE_WIDTH, GAIN_WIDTH, NUM_VOICES);
  localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_VOICES - 1);
  localparam logic [GAIN_WIDTH:0]   P_FULL   = {1'b1, {GAIN_WIDTH{1'b0}}};
  localparam logic [GAIN_WIDTH:0]   P_HALF   = P_FULL >> 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DONE} state_e;

  // Drop the gain fraction (floor, via arithmetic shift) and clamp to the sample range.
  function automatic logic signed [SAMPLE_WIDTH-1:0] scale_sat(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> GAIN_WIDTH;
    if (sh > SAT_MAX) return SAT_MAX[SAMPLE_WIDTH-1:0];
    if (sh < SAT_MIN) return SAT_MIN[SAMPLE_WIDTH-1:0];
    return sh[SAMPLE_WIDTH-1:0];
  endfunction

  // Control state
  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  pan_mode_e                       mode_q, mode_d;
  logic signed [SAMPLE_WIDTH-1:0]  left_q, left_d, right_q, right_d;
  logic                            out_valid_q, out_valid_d;
  logic                            busy_q, busy_d;
  logic                            overrun_q, overrun_d;

  // Datapath state (captured per mix, no reset needed)
  logic signed [SAMPLE_WIDTH-1:0]  cap_v_q [NUM_VOICES];
  pan_mode_e                       cap_mode_q;
  logic [GAIN_WIDTH:0]             cap_p_q;
  logic signed [ACC_W-1:0]         acc_l_q, acc_r_q;

  logic                            accept;
  logic [GAIN_WIDTH:0]             p_auto;
  logic [GAIN_WIDTH:0]             spread_tab [NUM_VOICES];
  logic [GAIN_WIDTH:0]             pos, gain_l, gain_r;
  logic signed [GAIN_WIDTH+1:0]    gl_s, gr_s;
  logic signed [SAMPLE_WIDTH-1:0]  v_sel;
  logic signed [PROD_W-1:0]        prod_l, prod_r;

  assign accept = new_sample && (state_q == ST_IDLE);

  auto_pan_sweep #(
    .GAIN_WIDTH  (GAIN_WIDTH),
    .AUTO_PAN_DIV(AUTO_PAN_DIV)
  ) u_sweep (
    .clk    (clk),
    .reset_n(reset_n),
    .accept (accept),
    .p_auto (p_auto)
  );

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_spread
    assign spread_tab[gi] = (GAIN_WIDTH+1)'(spread_pos(gi, NUM_VOICES, 1 << GAIN_WIDTH));
  end

  // Gains come from the mode and sweep position captured with the sample, so
  // button presses and sweep steps during a mix cannot disturb it.
  always_comb begin
    pos = P_HALF;
    case (cap_mode_q)
      MODE_LEFT:   pos = '0;
      MODE_RIGHT:  pos = P_FULL;
      MODE_SPREAD: pos = spread_tab[idx_q];
      MODE_AUTO:   pos = cap_p_q;
      default:     pos = P_HALF;
    endcase
    gain_l = P_FULL - pos;
    gain_r = pos;
  end

  assign v_sel  = cap_v_q[idx_q];
  assign gl_s   = $signed({1'b0, gain_l});
  assign gr_s   = $signed({1'b0, gain_r});
  assign prod_l = PROD_W'(v_sel) * PROD_W'(gl_s);
  assign prod_r = PROD_W'(v_sel) * PROD_W'(gr_s);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    left_d      = left_q;
    right_d     = right_q;
    out_valid_d = 1'b0;
    overrun_d   = new_sample && (state_q != ST_IDLE);

    if (button_press) begin
      case (mode_q)
        MODE_MONO:   mode_d = MODE_LEFT;
        MODE_LEFT:   mode_d = MODE_RIGHT;
        MODE_RIGHT:  mode_d = MODE_SPREAD;
        MODE_SPREAD: mode_d = MODE_AUTO;
        default:     mode_d = MODE_MONO;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (new_sample) begin
          state_d = ST_ACCUM;
          idx_d   = '0;
        end
      end
      ST_ACCUM: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        left_d      = scale_sat(acc_l_q);
        right_d     = scale_sat(acc_r_q);
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      mode_q      <= MODE_MONO;
      left_q      <= '0;
      right_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      left_q      <= left_d;
      right_q     <= right_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        cap_v_q[i] <= voice_samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
      cap_mode_q <= mode_q;
      cap_p_q    <= p_auto;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
    end else if (state_q == ST_ACCUM) begin
      acc_l_q <= acc_l_q + ACC_W'(prod_l);
      acc_r_q <= acc_r_q + ACC_W'(prod_r);
    end
  end

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign mode         = mode_q;

endmodule

// File: tb/tb_stereo_pan_mixer.sv
// Self-checking bench for stereo_pan_mixer (3 voices, 16-bit, G=16, sweep divider 2).
module tb_stereo_pan_mixer;

  localparam int NV  = 3;
  localparam int SW  = 16;
  localparam int GW  = 4;
  localparam int DIV = 2;
  localparam int G   = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              button_press;
  logic              new_sample;
  logic [NV*SW-1:0]  voice_samples;
  logic [SW-1:0]     left_sample;
  logic [SW-1:0]     right_sample;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic [2:0]        mode;

  stereo_pan_mixer #(
    .NUM_VOICES  (NV),
    .SAMPLE_WIDTH(SW),
    .GAIN_WIDTH  (GW),
    .AUTO_PAN_DIV(DIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .button_press (button_press),
    .new_sample   (new_sample),
    .voice_samples(voice_samples),
    .left_sample  (left_sample),
    .right_sample (right_sample),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int model_mode = 0;  // mode the bench believes the DUT is in
  int n_acc = 0;       // samples accepted since the last reset

  typedef struct {
    int presses;
    int v0;
    int v1;
    int v2;
    int exp_mode;
    int exp_l;
    int exp_r;
  } vec_t;

  vec_t tab [8];
  int   p_tab [20];

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic int s16(input logic [SW-1:0] x);
    return int'($signed(x));
  endfunction

  function automatic logic [NV*SW-1:0] pack(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  // Triangle pan position seen by the k-th accepted sample after reset.
  function automatic int ref_pauto(input int k);
    int t;
    t = (G / 2 + k / DIV) % (2 * G);
    return (t <= G) ? t : 2 * G - t;
  endfunction

  // Mix with floor division by G and clamping to the 16-bit range.
  function automatic int ref_mix(input int v0, input int v1, input int v2,
                                 input int m, input int pa, input bit right);
    int v [3];
    int p;
    int sum;
    int q;
    v[0] = v0; v[1] = v1; v[2] = v2;
    sum = 0;
    for (int i = 0; i < 3; i++) begin
      case (m)
        0:       p = G / 2;
        1:       p = 0;
        2:       p = G;
        3:       p = (i * G) / (NV - 1);
        default: p = pa;
      endcase
      sum += v[i] * (right ? p : G - p);
    end
    q = sum / G;
    if ((sum % G) != 0 && sum < 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic press();
    @(negedge clk);
    button_press = 1'b1;
    @(negedge clk);
    button_press = 1'b0;
    model_mode = (model_mode + 1) % 5;
  endtask

  task automatic run_sample(input int v0, input int v1, input int v2,
                            input bit press_same, input bit press_mid,
                            output int got_l, output int got_r,
                            output int lat, output int busy_cyc);
    @(negedge clk);
    voice_samples = pack(v0, v1, v2);
    new_sample    = 1'b1;
    button_press  = press_same;
    @(negedge clk);
    new_sample   = 1'b0;
    button_press = 1'b0;
    if (press_same) model_mode = (model_mode + 1) % 5;
    n_acc++;
    lat = 0;
    busy_cyc = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cyc++;
      button_press = press_mid && (lat == 1);
      if (press_mid && lat == 1) model_mode = (model_mode + 1) % 5;
      @(negedge clk);
      lat++;
    end
    button_press = 1'b0;
    got_l = s16(left_sample);
    got_r = s16(right_sample);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gl, gr, lat, bc, el, er, ov_cnt, vcnt, np, v0, v1, v2;
    bit ps, pm;
    logic [SW-1:0] rv;

    tab[0] = '{0,   1000,   1000,   1000, 0,   1500,  1500};
    tab[1] = '{1,  10000,  10000,  10000, 1,  30000,     0};
    tab[2] = '{0,  20000,  20000,  20000, 1,  32767,     0};
    tab[3] = '{0, -32768, -32768, -32768, 1, -32768,     0};
    tab[4] = '{1,  -1000,   2000,  -3000, 2,      0, -2000};
    tab[5] = '{1,   1600,      0,      0, 3,   1600,     0};
    tab[6] = '{0,      0,   1600,      0, 3,    800,   800};
    tab[7] = '{0,      0,      0,   1600, 3,      0,  1600};
    p_tab = '{8, 8, 9, 9, 10, 10, 11, 11, 12, 12, 13, 13, 14, 14, 15, 15, 16, 16, 15, 15};

    reset_n = 1'b0;
    button_press = 1'b0;
    new_sample = 1'b0;
    voice_samples = '0;
    repeat (3) @(negedge clk);
    check("rst_left", s16(left_sample), 0);
    check("rst_right", s16(right_sample), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_mode", int'(mode), 0);
    reset_n = 1'b1;

    // Fixed-mode vectors
    for (int i = 0; i < 8; i++) begin
      repeat (tab[i].presses) press();
      check($sformatf("tab%0d_mode", i), int'(mode), tab[i].exp_mode);
      run_sample(tab[i].v0, tab[i].v1, tab[i].v2, 1'b0, 1'b0, gl, gr, lat, bc);
      check($sformatf("tab%0d_left", i), gl, tab[i].exp_l);
      check($sformatf("tab%0d_right", i), gr, tab[i].exp_r);
      check($sformatf("tab%0d_latency", i), lat, 4);
      if (i == 0) begin
        check("mono_busy_cycles", bc, 4);
        check("mono_busy_at_valid", int'(busy), 0);
        @(negedge clk);
        check("mono_valid_single", int'(out_valid), 0);
      end
    end

    // AUTO sweep from reset, with an overrun on the first sample
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_mode = 0;
    n_acc = 0;
    repeat (4) press();
    check("auto_mode", int'(mode), 4);

    ov_cnt = 0; vcnt = 0; gl = 0; gr = 0;
    @(negedge clk);
    voice_samples = pack(1600, 0, 0);
    new_sample = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (overrun) ov_cnt++;
      if (out_valid) begin
        vcnt++;
        gl = s16(left_sample);
        gr = s16(right_sample);
      end
      new_sample = (c == 2);
      if (c == 2) voice_samples = pack(-5000, 7000, 3);
    end
    new_sample = 1'b0;
    n_acc++;
    check("ovr_pulses", ov_cnt, 1);
    check("ovr_valid_count", vcnt, 1);
    check("ovr_left", gl, 800);
    check("ovr_right", gr, 800);

    for (int k = 1; k < 20; k++) begin
      run_sample(1600, 0, 0, 1'b0, 1'b0, gl, gr, lat, bc);
      check($sformatf("auto%0d_right", k), gr, 100 * p_tab[k]);
      check($sformatf("auto%0d_left", k), gl, 100 * (G - p_tab[k]));
    end
    press();
    check("auto_wrap_mode", int'(mode), 0);

    // Reset in the middle of a LEFT mix
    press();
    run_sample(10000, 10000, 10000, 1'b0, 1'b0, gl, gr, lat, bc);
    check("pre_rst_left", gl, 30000);
    @(negedge clk);
    voice_samples = pack(-1000, -1000, -1000);
    new_sample = 1'b1;
    @(negedge clk);
    new_sample = 1'b0;
    @(negedge clk);
    check("mid_busy", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_left", s16(left_sample), 0);
    check("mid_rst_right", s16(right_sample), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    check("mid_rst_mode", int'(mode), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_mode = 0;
    n_acc = 0;
    run_sample(1000, 1000, 1000, 1'b0, 1'b0, gl, gr, lat, bc);
    check("post_rst_left", gl, 1500);
    check("post_rst_right", gr, 1500);
    check("post_rst_latency", lat, 4);

    // Randomized mixes against the reference model
    for (int i = 0; i < 40; i++) begin
      np = $urandom_range(0, 2);
      repeat (np) press();
      rv = 16'($urandom); v0 = s16(rv);
      rv = 16'($urandom); v1 = s16(rv);
      rv = 16'($urandom); v2 = s16(rv);
      if (i % 6 == 1) begin
        v0 = 32767; v1 = 32767; v2 = 32767;
      end
      ps = (i % 5 == 3);
      pm = (i % 7 == 2);
      el = ref_mix(v0, v1, v2, model_mode, ref_pauto(n_acc), 1'b0);
      er = ref_mix(v0, v1, v2, model_mode, ref_pauto(n_acc), 1'b1);
      run_sample(v0, v1, v2, ps, pm, gl, gr, lat, bc);
      check($sformatf("rnd%0d_left", i), gl, el);
      check($sformatf("rnd%0d_right", i), gr, er);
      check($sformatf("rnd%0d_mode", i), int'(mode), model_mode);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
